// File: rtl/rca_seq16_pkg.sv
// rca_seq_pkg: shared widths, slice count and FSM state encoding for the sequential adder
package rca_seq_pkg;
  localparam int WIDTH_D = 16;
  localparam int SLICE_D = 4;
  localparam int NSLICE_D = WIDTH_D / SLICE_D;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/rca_seq16_if.sv
// rca_seq16_if: operand/result handshake bundle for the sequential adder
interface rca_seq16_if #(parameter int WIDTH = rca_seq_pkg::WIDTH_D);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic cin;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] s;
  logic cout;
  logic busy;
  modport master (output in_valid, a, b, cin, out_ready, input in_ready, out_valid, s, cout, busy);
  modport slave (input in_valid, a, b, cin, out_ready, output in_ready, out_valid, s, cout, busy);
endinterface

// File: rtl/rca_seq16_rca4.sv
// rca4: 4-bit ripple-carry adder slice
module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;
  assign c[0] = ci;
  for (genvar g = 0; g < 4; g++) begin : g_fa
    assign s[g] = a[g] ^ b[g] ^ c[g];
    assign c[g+1] = (a[g] & b[g]) | (c[g] & (a[g] ^ b[g]));
  end
  assign co = c[4];
endmodule

// File: rtl/rca_seq16.sv
// rca_seq16: sequential adder that ripples one shared slice across the operands per cycle
module rca_seq16
  import rca_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int SLICE = SLICE_D
) (
  input logic clk,
  input logic rst,
  rca_seq16_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  state_t st;
  logic [WIDTH-1:0] a_reg, b_reg, s_reg;
  logic carry, cout_reg, sl_co;
  logic [IW-1:0] idx;
  logic [SLICE-1:0] sl_a, sl_b, sl_s;
  assign sl_a = a_reg[idx*SLICE +: SLICE];
  assign sl_b = b_reg[idx*SLICE +: SLICE];
  rca4 u_slice (.a(sl_a), .b(sl_b), .ci(carry), .s(sl_s), .co(sl_co));
  assign bus.in_ready = (st == IDLE) && !rst;
  assign bus.out_valid = st == DONE;
  assign bus.busy = st != IDLE;
  assign bus.s = s_reg;
  assign bus.cout = cout_reg;
  always_ff @(posedge clk) begin
    if (rst) begin
      st <= IDLE;
      idx <= '0;
      carry <= 1'b0;
      s_reg <= '0;
      cout_reg <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      case (st)
        IDLE: if (bus.in_valid) begin
          a_reg <= bus.a;
          b_reg <= bus.b;
          carry <= bus.cin;
          idx <= '0;
          s_reg <= '0;
          st <= RUN;
        end
        RUN: begin
          s_reg[idx*SLICE +: SLICE] <= sl_s;
          carry <= sl_co;
          idx <= idx + 1'b1;
          if (idx == IW'(NSLICE - 1)) begin
            cout_reg <= sl_co;
            st <= DONE;
          end
        end
        DONE: if (bus.out_ready) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule
